// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit -- IF-stage instruction fetch engine
//
// Purpose:
//   Holds the program counter and runs the instruction-bus request/acknowledge
//   handshake. Each fetched word, together with its PC, goes to the IF/ID
//   pipeline register. The unit follows the pipeline stall vector, taken
//   branches from ID, and flush/new_pc redirects from the controller. While a
//   word is still outstanding it asserts stallreq_if.
//
// Configuration macro:
//   IF_ADEL_EXC_EN - when defined, a misaligned PC (pc[1:0] != 0) does not
//                    start a bus cycle. The unit raises if_adel instead, so an
//                    address-error exception can travel down the pipeline.
//                    When undefined, pc[1:0] is ignored and every fetch
//                    address is forced to word alignment.
//
// Parameters:
//   RESET_PC       PC loaded by reset.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous, active-high reset
//   stall[5:0]     pipeline stall vector; only bit 0 (PC/IF stage) is used here
//   flush          exception flush; redirect to new_pc
//   new_pc[31:0]   exception handler / ERET target
//   branch_flag    ID-stage branch/jump taken
//   branch_target  taken-branch destination
//   ibus_req       bus request; held until ibus_ack
//   ibus_addr      word-aligned fetch address
//   ibus_ack       read data valid this cycle; ends the transaction
//   ibus_rdata     instruction word
//   if_pc          PC of the word presented to IF/ID
//   if_inst        instruction presented to IF/ID; 0 (NOP) when none
//   stallreq_if    stall request to the pipeline controller
//   if_adel        (IF_ADEL_EXC_EN only) fetch address error
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
`ifdef IF_ADEL_EXC_EN
  ,
  output logic        if_adel
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,   // dead cycle after reset
    S_REQ,    // request at pc outstanding (or issued back to back)
    S_HOLD,   // word captured, pipeline stalled; replay it from inst_buf
    S_FLUSH   // redirect pending; finish the abandoned bus cycle first
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] flush_addr_q, flush_addr_d;

  logic [31:0] next_pc;
  logic [31:0] fetch_addr;
  logic        addr_err;    // misaligned PC while in S_REQ
  logic        word_done;   // S_REQ completes this cycle (ack or address error)
  logic [31:0] word_data;   // word delivered when word_done is set

  // This unit only uses the IF-stage stall bit. The later bits are collapsed
  // here so that leaving them unconnected is a deliberate choice.
  wire unused_stall = &{1'b0, stall[5:1]};

  // The sequential successor. The 32-bit addition wraps 32'hFFFF_FFFC to 0.
  assign next_pc    = branch_flag ? branch_target : (pc_q + 32'd4);
  assign fetch_addr = {pc_q[31:2], 2'b00};

`ifdef IF_ADEL_EXC_EN
  assign addr_err = (state_q == S_REQ) && (pc_q[1:0] != 2'b00);
  assign if_adel  = addr_err;
`else
  assign addr_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments.
  // This way every register samples the values from before the edge, no
  // matter in what order the simulator evaluates the blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      // NOTE: inst_buf is one register, not a storage array. It is cleared
      // so that a replay from S_HOLD can never present stale or X data.
      inst_buf_q   <= '0;
      flush_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_buf_q   <= inst_buf_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // Priority at each edge: flush > stall[0] > branch > sequential.
  always_comb begin
    // NOTE: every signal driven in this block gets a default value first.
    // Then no path through the case statement can leave a signal unassigned
    // and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    inst_buf_d   = inst_buf_q;
    flush_addr_d = flush_addr_q;
    ibus_req     = 1'b0;
    ibus_addr    = '0;
    if_pc        = pc_q;
    if_inst      = '0;
    stallreq_if  = 1'b0;
    word_done    = 1'b0;
    word_data    = '0;

    unique case (state_q)
      S_IDLE: begin
        // Flush and stall are ignored here. The first request goes out one
        // cycle after reset is released.
        state_d = S_REQ;
      end

      S_REQ: begin
        if (addr_err) begin
          // A misaligned PC starts no bus cycle. It is handled as an
          // immediate completion with a NOP so that the exception advances.
          word_done = 1'b1;
          word_data = '0;
        end else begin
          ibus_req  = 1'b1;
          ibus_addr = fetch_addr;
          word_done = ibus_ack;
          word_data = ibus_rdata;
        end
        stallreq_if = !word_done;

        if (flush) begin
          pc_d = new_pc;
          if (word_done) begin
            // The word returned in the flush cycle is dropped, and inst_buf
            // keeps its old value.
            state_d = S_REQ;
          end else begin
            // The bus cycle must still finish at the address it started with.
            // Keep that address, and keep the request up, until the ack.
            flush_addr_d = fetch_addr;
            state_d      = S_FLUSH;
          end
        end else if (word_done) begin
          if_inst    = word_data;   // same-cycle bypass to IF/ID
          inst_buf_d = word_data;
          if (stall[0]) begin
            state_d = S_HOLD;
          end else begin
            pc_d = next_pc;         // back-to-back fetch
          end
        end
      end

      S_HOLD: begin
        if_inst = inst_buf_q;
        if (flush) begin
          pc_d    = new_pc;
          state_d = S_REQ;
        end else if (!stall[0]) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end

      S_FLUSH: begin
        ibus_req    = 1'b1;
        ibus_addr   = flush_addr_q;
        if_pc       = '0;
        stallreq_if = 1'b1;
        // A repeated flush only changes the redirect target.
        if (flush) begin
          pc_d = new_pc;
        end
        // The read data from the abandoned cycle is discarded.
        if (ibus_ack) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
